// File: rtl/tlc_phase_ctrl_pkg.sv
// Shared types and lamp codes for the N-phase traffic-light sequencer.
package tlc_pkg;

  typedef enum logic [1:0] {
    ALL_RED = 2'd0,
    GREEN   = 2'd1,
    YELLOW  = 2'd2,
    FLASH   = 2'd3
  } tlc_state_e;

  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_DARK   = 3'b000;

endpackage

// File: rtl/tlc_phase_ctrl_if.sv
// Control/lamp bundle between the tick prescaler, the sequencer and the lamp driver.
interface tlc_phase_ctrl_if #(
  parameter int NUM_PHASES = 4,
  parameter int CNT_W      = 8
);
  localparam int PH_W = $clog2(NUM_PHASES);

  logic                        tick;
  logic [NUM_PHASES*CNT_W-1:0] green_time;
  logic [CNT_W-1:0]            yellow_time;
  logic [NUM_PHASES-1:0]       demand;
  logic                        flash;
  logic [3*NUM_PHASES-1:0]     lights;
  logic [PH_W-1:0]             phase;
  logic [1:0]                  state;

  modport master (output tick, green_time, yellow_time, demand, flash,
                  input  lights, phase, state);
  modport slave  (input  tick, green_time, yellow_time, demand, flash,
                  output lights, phase, state);
endinterface

// File: rtl/tlc_interval_timer.sv
// Interval down-counter: loads D-1 on state entry, expires on the tick seen at zero.
module tlc_interval_timer #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,  // duration D, already clamped to >= 1
  input  logic             tick,
  output logic [CNT_W-1:0] count,
  output logic             expire
);
  logic [CNT_W-1:0] r_count;

  // load has priority so a state entry always restarts the interval
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           r_count <= RST_VAL;
    else if (load)                     r_count <= load_val - CNT_W'(1);
    else if (tick && r_count != '0)    r_count <= r_count - CNT_W'(1);
  end

  assign count  = r_count;
  assign expire = tick && (r_count == '0);
endmodule

// File: rtl/tlc_phase_ctrl.sv
// N-phase traffic-light sequencer: GREEN -> YELLOW -> ALL_RED per served phase,
// round-robin demand skipping, Moore lamp decode.
// Optional maintenance flash mode enabled by defining TLC_FLASH_EN.
module tlc_phase_ctrl
  import tlc_pkg::*;
#(
  parameter int NUM_PHASES   = 4,
  parameter int CNT_W        = 8,
  parameter int ALL_RED_TIME = 1
) (
  input logic            clk,
  input logic            rst,
  tlc_phase_ctrl_if.slave bus
);
  localparam int               PH_W    = $clog2(NUM_PHASES);
  localparam logic [CNT_W-1:0] AR_D    = (ALL_RED_TIME == 0) ? CNT_W'(1) : CNT_W'(ALL_RED_TIME);
  localparam logic [PH_W-1:0]  LAST_PH = PH_W'(NUM_PHASES - 1);

  function automatic logic [CNT_W-1:0] clamp_d(input logic [CNT_W-1:0] d);
    return (d == '0) ? CNT_W'(1) : d;
  endfunction

  tlc_state_e                        r_state, w_nxt_state;
  logic [PH_W-1:0]                   r_phase, w_nxt_phase, w_rr_phase;
  logic                              w_load, w_expire, w_flash;
  logic [CNT_W-1:0]                  w_load_val, w_cnt_unused;
  logic [NUM_PHASES-1:0][CNT_W-1:0]  w_green;
  logic [NUM_PHASES-1:0][2:0]        w_lights;

  assign w_green = bus.green_time;

`ifdef TLC_FLASH_EN
  logic r_blink;
  assign w_flash = bus.flash;

  // blink phase restarts lit on flash entry, then toggles on every tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_blink <= 1'b0;
    else if (r_state != FLASH)  r_blink <= 1'b0;
    else if (bus.tick)          r_blink <= ~r_blink;
  end
`else
  logic w_flash_unused;
  assign w_flash_unused = bus.flash;
  assign w_flash        = 1'b0;
`endif

  tlc_interval_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (AR_D - CNT_W'(1))
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (w_load_val),
    .tick     (bus.tick),
    .count    (w_cnt_unused),
    .expire   (w_expire)
  );

  // round-robin: first demanding phase after r_phase, r_phase itself last
  always_comb begin
    w_rr_phase = PH_W'((int'(r_phase) + 1) % NUM_PHASES);
    for (int k = NUM_PHASES; k >= 1; k--) begin
      if (bus.demand[PH_W'((int'(r_phase) + k) % NUM_PHASES)])
        w_rr_phase = PH_W'((int'(r_phase) + k) % NUM_PHASES);
    end
  end

  // state and served-phase registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ALL_RED;
      r_phase <= LAST_PH;
    end else begin
      r_state <= w_nxt_state;
      r_phase <= w_nxt_phase;
    end
  end

  // next state: flash overrides everything, otherwise advance on timer expiry
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_phase = r_phase;
    w_load      = 1'b0;
    w_load_val  = AR_D;
    if (r_state == FLASH) begin
      if (!w_flash) begin
        w_nxt_state = ALL_RED;
        w_nxt_phase = LAST_PH;
        w_load      = 1'b1;
      end
    end else if (w_flash) begin
      w_nxt_state = FLASH;
    end else if (w_expire) begin
      w_load = 1'b1;
      case (r_state)
        GREEN: begin
          w_nxt_state = YELLOW;
          w_load_val  = clamp_d(bus.yellow_time);
        end
        YELLOW: begin
          w_nxt_state = ALL_RED;
          w_load_val  = AR_D;
        end
        default: begin
          w_nxt_state = GREEN;
          w_nxt_phase = w_rr_phase;
          w_load_val  = clamp_d(w_green[w_rr_phase]);
        end
      endcase
    end
  end

  // Moore lamp decode; unreachable codes fall back to all-red
  always_comb begin
    w_lights = {NUM_PHASES{LAMP_RED}};
    case (r_state)
      GREEN:   w_lights[r_phase] = LAMP_GREEN;
      YELLOW:  w_lights[r_phase] = LAMP_YELLOW;
`ifdef TLC_FLASH_EN
      FLASH:   w_lights = {NUM_PHASES{r_blink ? LAMP_DARK : LAMP_YELLOW}};
`endif
      default: ;
    endcase
  end

  assign bus.lights = w_lights;
  assign bus.phase  = r_phase;
  assign bus.state  = r_state;
endmodule

// File: tb/tb_tlc_phase_ctrl.sv
// Self-checking bench for tlc_phase_ctrl: spec-derived cycle table, directed
// corner sequences, and randomized traffic against a tick-counting reference model.
module tb_tlc_phase_ctrl;
  localparam int N = 4, CW = 8, ART = 1;
`ifdef TLC_FLASH_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tlc_phase_ctrl_if #(.NUM_PHASES(N), .CNT_W(CW)) bus ();
  tlc_phase_ctrl #(.NUM_PHASES(N), .CNT_W(CW), .ALL_RED_TIME(ART)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );

  int n_vec = 0, n_err = 0;

  // reference model: segment (0 red, 1 green, 2 yellow, 3 flash), phase, ticks remaining
  int m_seg, m_ph, m_rem;
  bit m_blink;

  typedef struct { bit tk; int st; int ph; } vec_t;
  vec_t tbl[$];

  function automatic logic [3*N-1:0] lamps(int seg, int ph, bit bl);
    logic [3*N-1:0] l;
    for (int p = 0; p < N; p++) begin
      if (seg == 3)                 l[p*3 +: 3] = bl ? 3'b000 : 3'b010;
      else if (p == ph && seg == 1) l[p*3 +: 3] = 3'b001;
      else if (p == ph && seg == 2) l[p*3 +: 3] = 3'b010;
      else                          l[p*3 +: 3] = 3'b100;
    end
    return l;
  endfunction

  function automatic int dur(int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic m_reset();
    m_seg = 0; m_ph = N - 1; m_rem = ART; m_blink = 1'b0;
  endtask

  task automatic m_edge(input bit tk, input bit fl, input logic [N-1:0] dem,
                        input logic [N*CW-1:0] gt, input logic [CW-1:0] yt);
    int nx;
    if (FL && fl) begin
      if (m_seg != 3) begin m_seg = 3; m_blink = 1'b0; end
      else if (tk)    m_blink = ~m_blink;
    end else if (m_seg == 3) begin
      m_reset();
    end else if (tk) begin
      m_rem--;
      if (m_rem == 0) begin
        case (m_seg)
          0: begin
            nx = (m_ph + 1) % N;
            for (int k = N; k >= 1; k--) if (dem[(m_ph + k) % N]) nx = (m_ph + k) % N;
            m_ph = nx; m_seg = 1;
            m_rem = dur(int'(CW'(gt >> (nx * CW))));
          end
          1: begin m_seg = 2; m_rem = dur(int'(yt)); end
          default: begin m_seg = 0; m_rem = ART; end
        endcase
      end
    end
  endtask

  task automatic cmp_exp(input string nm, input int st, input int ph, input bit bl);
    logic [3*N-1:0] el;
    el = lamps(st, ph, bl);
    n_vec++;
    if (bus.lights !== el || bus.phase !== 2'(ph) || bus.state !== 2'(st)) begin
      n_err++;
      $display("FAIL %s @%0t: got lights=%h phase=%0d state=%0d, want lights=%h phase=%0d state=%0d",
               nm, $time, bus.lights, bus.phase, bus.state, el, ph, st);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h want %0h", nm, $time, got, exp);
    end
  endtask

  task automatic step(input bit tk, input bit fl, input string nm);
    bus.tick = tk; bus.flash = fl;
    @(posedge clk);
    m_edge(tk, fl, bus.demand, bus.green_time, bus.yellow_time);
    #1;
    cmp_exp(nm, m_seg, m_ph, m_blink);
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.tick = 1'b0; bus.flash = 1'b0;
    m_reset();
    @(posedge clk); #1;
    cmp_exp("reset", m_seg, m_ph, m_blink);
    rst = 1'b0;
  endtask

  initial begin
    int g0, y0, prev, found, hold;
    int served[$];
    rst = 1'b1;
    bus.tick = 1'b0; bus.flash = 1'b0; bus.demand = '1;
    bus.green_time = {N{8'd3}}; bus.yellow_time = 8'd2;

    // full cycle: expected per-edge state/phase from the published timing
    for (int p = 0; p < N; p++) begin
      repeat (3) tbl.push_back('{1'b1, 1, p});
      repeat (2) tbl.push_back('{1'b1, 2, p});
      tbl.push_back('{1'b1, 0, p});
    end
    tbl.push_back('{1'b1, 1, 0});
    do_reset();
    foreach (tbl[i]) begin
      bus.tick = tbl[i].tk;
      @(posedge clk); #1;
      cmp_exp("full cycle", tbl[i].st, tbl[i].ph, 1'b0);
    end

    // demand skip
    bus.demand = 4'b0101;
    do_reset();
    prev = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 1'b0, "skip");
      if (bus.state == 2'd1 && prev != 1) served.push_back(int'(bus.phase));
      prev = int'(bus.state);
    end
    for (int i = 0; i < 4; i++)
      chk("skip order", (i < served.size()) ? served[i] : 99, (i % 2) * 2);

    // zero green and yellow sampled at entry
    bus.demand = '1;
    bus.green_time = {8'd3, 8'd3, 8'd3, 8'd0};
    bus.yellow_time = 8'd2;
    do_reset();
    g0 = 0; y0 = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, "zero/sample");
      if (bus.state == 2'd1 && bus.phase == 2'd0) g0++;
      if (bus.state == 2'd2 && bus.phase == 2'd0) begin y0++; bus.yellow_time = 8'd5; end
    end
    chk("zero green", g0, 1);
    chk("yellow sampled", y0, 2);
    bus.green_time = {N{8'd3}}; bus.yellow_time = 8'd2;

    // sparse tick
    do_reset();
    g0 = 0;
    for (int i = 0; i < 40; i++) begin
      step(i % 4 == 3, 1'b0, "sparse");
      if (bus.state == 2'd1 && bus.phase == 2'd0) g0++;
    end
    chk("sparse green cycles", g0, 12);

    // async reset mid-yellow
    do_reset();
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      step(1'b1, 1'b0, "to yellow");
      if (bus.state == 2'd2) found = 1;
    end
    chk("reach yellow", found, 1);
    #2; rst = 1'b1; m_reset(); #1;
    chk("async lights", bus.lights, {N{3'b100}});
    chk("async state", bus.state, 0);
    chk("async phase", bus.phase, 3);
    @(posedge clk); #1; rst = 1'b0;
    step(1'b1, 1'b0, "restart");
    chk("restart phase", bus.phase, 0);
    chk("restart state", bus.state, 1);

    // flash entry/toggle/exit (ignored when the mode is not built)
    do_reset();
    step(1'b1, 1'b0, "pre flash");
    step(1'b1, 1'b0, "pre flash");
    step(1'b0, 1'b1, "flash on");
`ifdef TLC_FLASH_EN
    chk("flash lit", bus.lights, {N{3'b010}});
`endif
    step(1'b1, 1'b1, "flash tick");
`ifdef TLC_FLASH_EN
    chk("flash dark", bus.lights, {N{3'b000}});
`endif
    step(1'b1, 1'b1, "flash tick");
    step(1'b0, 1'b1, "flash hold");
    step(1'b1, 1'b0, "flash exit");
`ifdef TLC_FLASH_EN
    chk("flash exit state", bus.state, 0);
    chk("flash exit phase", bus.phase, 3);
`endif
    step(1'b1, 1'b0, "after flash");
`ifdef TLC_FLASH_EN
    chk("after flash green", {bus.state, bus.phase}, {2'd1, 2'd0});
`endif

    // randomized traffic
    do_reset();
    hold = 0;
    for (int i = 0; i < 800; i++) begin
      bit fl;
      if (i % 25 == 0) bus.demand = 4'($urandom_range(0, 15));
      if (i % 40 == 0) begin
        for (int p = 0; p < N; p++) bus.green_time[p*CW +: CW] = 8'($urandom_range(0, 4));
        bus.yellow_time = 8'($urandom_range(0, 3));
      end
      if (hold > 0) begin fl = 1'b1; hold--; end
      else begin
        fl = 1'b0;
        if ($urandom_range(0, 79) == 0) hold = $urandom_range(1, 6);
      end
      step($urandom_range(0, 2) == 0, fl, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
